// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register bank, 2 comb reads, 1 sync write.
// Ports:
//   CLK         clock; all state updates on the rising edge
//   RST         synchronous active-high reset
//   WE          write enable
//   WADDR       write address
//   WDATA       write data
//   WBE         byte-lane enables, bit i covers WDATA[8i+7:8i]
//   RADDR1/2    read addresses
//   RDATA1/2    combinational read data
module reg_file_param #(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         NB       = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [NB-1:0]    WBE,
    input  logic [AW-1:0]    RADDR1,
    input  logic [AW-1:0]    RADDR2,
    output logic [WIDTH-1:0] RDATA1,
    output logic [WIDTH-1:0] RDATA2
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] wr_d;
    logic             wr_ok;
    logic             byp1;
    logic             byp2;

    // Address maps to a real, writable entry (not beyond DEPTH,
    // not the hardwired zero entry).
    function automatic logic writable(input logic [AW-1:0] a);
        logic ok;
        ok = (32'(a) < 32'(DEPTH));
        if (ZERO_REG && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [WIDTH-1:0] stored(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (writable(a)) begin
            v = mem_q[a];
        end
        return v;
    endfunction

    assign wr_ok = WE && !RST && writable(WADDR);

    // Merged post-write value of the target entry; used both for the
    // store and for forwarding, so the bypass always matches the result.
    always_comb begin
        wr_d = stored(WADDR);
        for (int b = 0; b < NB; b++) begin
            if (WBE[b]) begin
                wr_d[8*b +: 8] = WDATA[8*b +: 8];
            end
        end
    end

    assign byp1 = BYPASS && wr_ok && (RADDR1 == WADDR);
    assign byp2 = BYPASS && wr_ok && (RADDR2 == WADDR);

    assign RDATA1 = byp1 ? wr_d : stored(RADDR1);
    assign RDATA2 = byp2 ? wr_d : stored(RADDR2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ZERO_REG && (i == 0)) begin
                    mem_q[i] <= '0;
                end else begin
                    mem_q[i] <= RST_VAL;
                end
            end
        end else if (wr_ok) begin
            mem_q[WADDR] <= wr_d;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of reg_file_param in two configs.
// u0: DEADBEEF reset, zero reg, bypass; u1: DEPTH=20, no zero, no bypass.
module tb_reg_file_param;

    logic        CLK;
    logic        RST;
    logic        WE;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic [3:0]  WBE;
    logic [4:0]  RADDR1;
    logic [4:0]  RADDR2;
    logic [31:0] r0_1, r0_2;
    logic [31:0] r1_1, r1_2;

    int n_chk;
    int n_fail;

    reg_file_param #(
        .WIDTH(32), .DEPTH(32), .RST_VAL(32'hDEADBEEF),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u0 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .WBE(WBE), .RADDR1(RADDR1),
        .RADDR2(RADDR2), .RDATA1(r0_1), .RDATA2(r0_2)
    );

    reg_file_param #(
        .WIDTH(32), .DEPTH(20), .RST_VAL(32'h0),
        .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) u1 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .WBE(WBE), .RADDR1(RADDR1),
        .RADDR2(RADDR2), .RDATA1(r1_1), .RDATA2(r1_2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        RADDR1 = a;
        RADDR2 = a;
        #1;
    endtask

    task automatic wr(input logic [4:0] a,
                      input logic [31:0] d,
                      input logic [3:0] be);
        WE = 1'b1;
        WADDR = a;
        WDATA = d;
        WBE = be;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        RST = 1'b1;
        WE = 1'b0;
        WADDR = '0;
        WDATA = '0;
        WBE = '0;
        RADDR1 = '0;
        RADDR2 = '0;
        tick();
        RST = 1'b0;

        // reset state
        for (int a = 0; a < 32; a++) begin
            rd(5'(a));
            check($sformatf("rst_u0_p1_%0d", a), r0_1,
                  (a == 0) ? 32'h0 : 32'hDEADBEEF);
            check($sformatf("rst_u0_p2_%0d", a), r0_2,
                  (a == 0) ? 32'h0 : 32'hDEADBEEF);
            check($sformatf("rst_u1_p1_%0d", a), r1_1, 32'h0);
        end

        // full write then byte-masked write
        wr(5'd5, 32'h12345678, 4'b1111);
        rd(5'd5);
        check("wr_full_u0", r0_1, 32'h12345678);
        check("wr_full_u1", r1_1, 32'h12345678);
        wr(5'd5, 32'hAABBCCDD, 4'b0101);
        rd(5'd5);
        check("wr_mask_u0", r0_1, 32'h12BB56DD);
        check("wr_mask_u1", r1_2, 32'h12BB56DD);

        // all-zero byte enable changes nothing
        wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        rd(5'd5);
        check("wbe0_u0", r0_1, 32'h12BB56DD);

        // bypass vs no bypass
        wr(5'd7, 32'h11111111, 4'b1111);
        WE = 1'b1;
        WADDR = 5'd7;
        WDATA = 32'hCAFEF00D;
        WBE = 4'b0011;
        rd(5'd7);
        check("byp_u0_p1", r0_1, 32'h1111F00D);
        check("byp_u0_p2", r0_2, 32'h1111F00D);
        check("nobyp_u1_p1", r1_1, 32'h11111111);
        check("nobyp_u1_p2", r1_2, 32'h11111111);
        tick();
        WE = 1'b0;
        #1;
        check("post_u0", r0_1, 32'h1111F00D);
        check("post_u1", r1_1, 32'h1111F00D);

        // entry 0
        WE = 1'b1;
        WADDR = 5'd0;
        WDATA = 32'hFFFFFFFF;
        WBE = 4'b1111;
        rd(5'd0);
        check("zero_same_u0", r0_1, 32'h0);
        check("zero_same_u1", r1_1, 32'h0);
        tick();
        WE = 1'b0;
        #1;
        check("zero_next_u0", r0_1, 32'h0);
        check("zero_next_u1", r1_1, 32'hFFFFFFFF);

        // out-of-range address on DEPTH=20
        wr(5'd9, 32'h00000009, 4'b1111);
        wr(5'd19, 32'h00000013, 4'b1111);
        WE = 1'b1;
        WADDR = 5'd25;
        WDATA = 32'h0000ABCD;
        WBE = 4'b1111;
        rd(5'd25);
        check("oor_same_u1", r1_1, 32'h0);
        check("oor_byp_u0", r0_1, 32'h0000ABCD);
        tick();
        WE = 1'b0;
        rd(5'd25);
        check("oor_rd_u1", r1_1, 32'h0);
        check("oor_wr_u0", r0_1, 32'h0000ABCD);
        rd(5'd5);
        check("oor_e5_u1", r1_1, 32'h12BB56DD);
        rd(5'd9);
        check("oor_e9_u1", r1_1, 32'h00000009);
        rd(5'd19);
        check("oor_e19_u1", r1_1, 32'h00000013);

        // reset beats write
        wr(5'd3, 32'h00000003, 4'b1111);
        RST = 1'b1;
        WE = 1'b1;
        WADDR = 5'd3;
        WDATA = 32'h55555555;
        WBE = 4'b1111;
        rd(5'd3);
        check("rstwr_same_u0", r0_1, 32'h00000003);
        check("rstwr_same_u1", r1_1, 32'h00000003);
        tick();
        RST = 1'b0;
        WE = 1'b0;
        #1;
        check("rstwr_e3_u0", r0_1, 32'hDEADBEEF);
        check("rstwr_e3_u1", r1_1, 32'h0);
        rd(5'd5);
        check("rstwr_e5_u0", r0_2, 32'hDEADBEEF);
        rd(5'd0);
        check("rstwr_e0_u1", r1_1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised multi-entry register bank: the generalised successor to the single 32-bit enable register.
- Provides DEPTH entries of WIDTH bits with a configurable reset value, byte-lane write masking, an optional hardwired-zero entry 0, and optional write-to-read bypass.
- Serves as the multicycle MIPS datapath's general-purpose register file: two combinational read ports, one synchronous write port.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 32, number of entries; need not be a power of two
RST_VAL, 0, value loaded into every entry (except a hardwired-zero entry 0) on reset
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary storage
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port; 0 = reads show stored contents only
AW (localparam), $clog2(DEPTH) (minimum 1), address width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, synchronous, active-high
WE  input  1  write enable
WADDR  input  AW  write address
WDATA  input  WIDTH  write data
WBE  input  WIDTH/8  byte-lane enable; bit i covers WDATA[8i+7:8i]
RADDR1  input  AW  read address, port 1
RADDR2  input  AW  read address, port 2
RDATA1  output  WIDTH  read data, port 1
RDATA2  output  WIDTH  read data, port 2

Behaviour:
- Reset
  - RST sampled high at a CLK rising edge: every entry <- RST_VAL; entry 0 <- 0 when ZERO_REG=1.
  - RST has priority over WE in the same cycle; the write is dropped.
  - RST low between edges has no effect (no asynchronous action).
  - Before the first reset, entry contents are undefined (X in simulation). Entry 0 with ZERO_REG=1 reads 0 regardless.
- Write
  - At a rising edge with WE=1, RST=0 and a valid WADDR: for each i with WBE[i]=1, byte i of entry WADDR <- WDATA byte i. Bytes with WBE[i]=0 are unchanged.
  - WBE all-zero: no entry changes.
  - Write latency is 1 cycle: data is visible through the stored path after the edge.
  - No-op writes:
    - WADDR >= DEPTH (possible only when DEPTH is not a power of two).
    - WADDR=0 with ZERO_REG=1.
- Read
  - Combinational; no clock latency.
  - RDATAx = 0 when RADDRx >= DEPTH.
  - RDATAx = 0 when RADDRx=0 and ZERO_REG=1.
  - Otherwise, RDATAx = stored entry RADDRx.
- Bypass (BYPASS=1)
  - Applies when WE=1, RST=0, and RADDRx == WADDR for a valid, writable address.
  - RDATAx = merged value: WDATA bytes where WBE=1, stored bytes elsewhere. This equals the value the entry will hold after the edge.
  - Suppressed while RST=1.
  - Never applies to hardwired entry 0.
  - Both ports may bypass simultaneously on the same address.
- BYPASS=0: reads show pre-edge stored contents only; new data is visible the cycle after the write.
- Simultaneous reads of the same address on both ports return identical data.
- No internal state other than the storage array. Outputs are never registered.
- Reset mid-operation: a write presented in the RST cycle is lost; entries return to RST_VAL at that edge.

Test Plan:
- RST_VAL=32'hDEADBEEF, DEPTH=32: assert RST one cycle, then read all addresses -> entry 0 reads 0; entries 1..31 read 32'hDEADBEEF.
- Write WADDR=5, WDATA=32'h12345678, WBE=4'b1111, then read RADDR1=5 next cycle -> 32'h12345678. Then write WDATA=32'hAABBCCDD, WBE=4'b0101 -> entry 5 reads 32'h12BB56DD.
- BYPASS=1: WE=1, WADDR=7, WDATA=32'hCAFEF00D, WBE=4'b0011, stored entry 7 = 32'h11111111, RADDR1=RADDR2=7 in the same cycle -> both ports read 32'h1111F00D before the edge. Repeat with BYPASS=0 -> 32'h11111111 before the edge, 32'h1111F00D after.
- ZERO_REG=1: write WADDR=0, WDATA=32'hFFFFFFFF, WBE=4'b1111 -> RDATA1 reads 0 both same-cycle and next cycle. With ZERO_REG=0 and RST_VAL=0 -> entry 0 reads 32'hFFFFFFFF after the edge.
- DEPTH=20, AW=5: write WADDR=25 with 32'h0000ABCD -> no entry changes (spot-check entries 5, 9 and 19 unchanged); RADDR1=25 reads 0.
- Entry 3 = 32'h00000003: RST=1 and WE=1 in the same cycle, WADDR=3, WDATA=32'h55555555 -> RDATA1 (RADDR1=3) shows the stored value while RST=1, no bypass. After the edge, entry 3 = RST_VAL, not 32'h55555555.
